// File: rtl/id_stage_pipe.sv
// RV32I decode stage with a registered ID/EX output, valid/ready handshake, load-use stall and flush.
// Define ID_STALL_CNT_EN to add the id_stall_cnt_o stall-cycle counter.
module id_stage_pipe #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RADDR_W   = 5,
    parameter int unsigned ALUCTRL_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 if_valid_i,
    output logic                 if_ready_o,
    input  logic [XLEN-1:0]      if_id_reg_pc_i,
    input  logic [31:0]          if_id_reg_inst_i,
    output logic [RADDR_W-1:0]   id_reg1_raddr_o,
    output logic [RADDR_W-1:0]   id_reg2_raddr_o,
    input  logic [XLEN-1:0]      regs_reg1_rdata_i,
    input  logic [XLEN-1:0]      regs_reg2_rdata_i,
    input  logic                 flush_i,
    input  logic                 ex_ready_i,
`ifdef ID_STALL_CNT_EN
    output logic [31:0]          id_stall_cnt_o,
`endif
    output logic                 id_valid_o,
    output logic [XLEN-1:0]      id_pc_o,
    output logic [XLEN-1:0]      id_op_a_o,
    output logic [XLEN-1:0]      id_op_b_o,
    output logic [XLEN-1:0]      id_store_data_o,
    output logic [XLEN-1:0]      id_imm_o,
    output logic [RADDR_W-1:0]   id_reg_waddr_o,
    output logic                 id_reg_we_o,
    output logic                 id_is_load_o,
    output logic                 id_is_store_o,
    output logic                 id_is_branch_o,
    output logic                 id_illegal_o,
    output logic [ALUCTRL_W-1:0] id_ALUctrl_o
);

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;

    typedef enum logic {StRun, StStall} state_e;

    typedef struct packed {
        logic [XLEN-1:0]      pc;
        logic [XLEN-1:0]      op_a;
        logic [XLEN-1:0]      op_b;
        logic [XLEN-1:0]      store_data;
        logic [XLEN-1:0]      imm;
        logic [RADDR_W-1:0]   waddr;
        logic                 we;
        logic                 is_load;
        logic                 is_store;
        logic                 is_branch;
        logic                 illegal;
        logic [ALUCTRL_W-1:0] alu_ctrl;
    } id_ex_t;

    state_e state_q, state_d;
    id_ex_t out_q, out_d, dec;
    logic   valid_q, valid_d;
    logic   rs1_used, rs2_used;
    logic   hazard, out_free, accept;

    logic [31:0]     inst;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm, imm_i, imm_s, imm_b, imm_u, imm_j;
    logic            op_b_rs2, rd_write;
    logic [4:0]      alu5;

    assign inst   = if_id_reg_inst_i;
    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];

    assign id_reg1_raddr_o = RADDR_W'(inst[19:15]);
    assign id_reg2_raddr_o = RADDR_W'(inst[24:20]);

    assign imm_i = XLEN'($signed(inst[31:20]));
    assign imm_s = XLEN'($signed({inst[31:25], inst[11:7]}));
    assign imm_b = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({inst[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));

    always_comb begin
        dec       = '0;
        imm       = '0;
        op_b_rs2  = 1'b0;
        rd_write  = 1'b0;
        alu5      = 5'b0;
        rs1_used  = 1'b1;
        rs2_used  = 1'b0;
        dec.pc    = if_id_reg_pc_i;
        dec.op_a  = regs_reg1_rdata_i;
        dec.waddr = RADDR_W'(inst[11:7]);
        case (opcode)
            OpLui: begin
                imm      = imm_u;
                dec.op_a = '0;
                rd_write = 1'b1;
                rs1_used = 1'b0;
            end
            OpAuipc: begin
                imm      = imm_u;
                dec.op_a = if_id_reg_pc_i;
                rd_write = 1'b1;
                rs1_used = 1'b0;
            end
            OpJal: begin
                imm           = imm_j;
                dec.op_a      = if_id_reg_pc_i;
                rd_write      = 1'b1;
                dec.is_branch = 1'b1;
                rs1_used      = 1'b0;
            end
            OpJalr: begin
                imm           = imm_i;
                rd_write      = 1'b1;
                dec.is_branch = 1'b1;
            end
            OpBranch: begin
                imm           = imm_b;
                op_b_rs2      = 1'b1;
                dec.is_branch = 1'b1;
                rs2_used      = 1'b1;
                alu5          = {2'b10, funct3};
            end
            OpLoad: begin
                imm         = imm_i;
                rd_write    = 1'b1;
                dec.is_load = 1'b1;
            end
            OpStore: begin
                imm            = imm_s;
                dec.is_store   = 1'b1;
                dec.store_data = regs_reg2_rdata_i;
                rs2_used       = 1'b1;
            end
            OpImm: begin
                imm      = imm_i;
                rd_write = 1'b1;
                // Only shifts-right carry the alt bit; elsewhere inst[30] is immediate data.
                alu5     = {1'b0, (funct3 == 3'b101) & inst[30], funct3};
            end
            OpReg: begin
                op_b_rs2 = 1'b1;
                rd_write = 1'b1;
                rs2_used = 1'b1;
                alu5     = {1'b0, inst[30], funct3};
            end
            default: dec.illegal = 1'b1;
        endcase
        dec.imm      = imm;
        dec.op_b     = op_b_rs2 ? regs_reg2_rdata_i : imm;
        dec.we       = rd_write && (inst[11:7] != 5'd0);
        dec.alu_ctrl = ALUCTRL_W'(alu5);
    end

    assign hazard = valid_q && out_q.is_load && (out_q.waddr != '0) &&
                    ((rs1_used && (out_q.waddr == id_reg1_raddr_o)) ||
                     (rs2_used && (out_q.waddr == id_reg2_raddr_o)));

    assign out_free   = !valid_q || ex_ready_i;
    assign if_ready_o = out_free && !hazard && !flush_i;
    assign accept     = if_valid_i && if_ready_o;

    // STALL marks the single bubble cycle; the held instruction is accepted on the way back to RUN.
    always_comb begin
        state_d = StRun;
        if (!flush_i && (state_q == StRun) && hazard && ex_ready_i) begin
            state_d = StStall;
        end
    end

    always_comb begin
        valid_d = valid_q;
        out_d   = out_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            out_d   = dec;
        end else if (out_free) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
            valid_q <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            out_q   <= out_d;
        end
    end

`ifdef ID_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'd0;
        end else if (if_valid_i && !if_ready_o) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign id_stall_cnt_o = stall_cnt_q;
`endif

    assign id_valid_o      = valid_q;
    assign id_pc_o         = out_q.pc;
    assign id_op_a_o       = out_q.op_a;
    assign id_op_b_o       = out_q.op_b;
    assign id_store_data_o = out_q.store_data;
    assign id_imm_o        = out_q.imm;
    assign id_reg_waddr_o  = out_q.waddr;
    assign id_reg_we_o     = out_q.we;
    assign id_is_load_o    = out_q.is_load;
    assign id_is_store_o   = out_q.is_store;
    assign id_is_branch_o  = out_q.is_branch;
    assign id_illegal_o    = out_q.illegal;
    assign id_ALUctrl_o    = out_q.alu_ctrl;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Scoreboard bench for id_stage_pipe: expected ID/EX records queued at issue, compared at output.
module tb_id_stage_pipe;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [31:0] sdata;
        logic [31:0] imm;
        logic [4:0]  waddr;
        logic        we;
        logic        ld;
        logic        st;
        logic        br;
        logic        ill;
        logic [4:0]  alu;
    } exp_t;

    logic        clk, rst_n, if_valid, if_ready, flush, ex_ready;
    logic [31:0] pc, inst, rdata1, rdata2;
    logic [4:0]  raddr1, raddr2;
    logic        id_valid, id_we, id_ld, id_st, id_br, id_ill;
    logic [31:0] id_pc, id_op_a, id_op_b, id_sdata, id_imm;
    logic [4:0]  id_waddr, id_alu;
    logic [31:0] rf [32];
    exp_t        obs;
    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
`ifdef ID_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    id_stage_pipe dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .if_valid_i        (if_valid),
        .if_ready_o        (if_ready),
        .if_id_reg_pc_i    (pc),
        .if_id_reg_inst_i  (inst),
        .id_reg1_raddr_o   (raddr1),
        .id_reg2_raddr_o   (raddr2),
        .regs_reg1_rdata_i (rdata1),
        .regs_reg2_rdata_i (rdata2),
        .flush_i           (flush),
        .ex_ready_i        (ex_ready),
`ifdef ID_STALL_CNT_EN
        .id_stall_cnt_o    (stall_cnt),
`endif
        .id_valid_o        (id_valid),
        .id_pc_o           (id_pc),
        .id_op_a_o         (id_op_a),
        .id_op_b_o         (id_op_b),
        .id_store_data_o   (id_sdata),
        .id_imm_o          (id_imm),
        .id_reg_waddr_o    (id_waddr),
        .id_reg_we_o       (id_we),
        .id_is_load_o      (id_ld),
        .id_is_store_o     (id_st),
        .id_is_branch_o    (id_br),
        .id_illegal_o      (id_ill),
        .id_ALUctrl_o      (id_alu)
    );

    assign obs = {id_pc, id_op_a, id_op_b, id_sdata, id_imm, id_waddr,
                  id_we, id_ld, id_st, id_br, id_ill, id_alu};
    assign rdata1 = rf[raddr1];
    assign rdata2 = rf[raddr2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'(i) << 4;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk(input logic [31:0] p, a, b, sd, im, input logic [4:0] wa,
                                input logic we, ld, st, br, ill, input logic [4:0] alu);
        return '{pc: p, op_a: a, op_b: b, sdata: sd, imm: im, waddr: wa,
                 we: we, ld: ld, st: st, br: br, ill: ill, alu: alu};
    endfunction

    // Called at a negedge; returns at the negedge after the instruction is taken.
    task automatic drive(input logic [31:0] p, input logic [31:0] ins, input exp_t e,
                         output int waits);
        sb.push_back(e);
        if_valid = 1'b1;
        pc       = p;
        inst     = ins;
        waits    = 0;
        #1;
        while (!if_ready && waits < 20) begin
            @(negedge clk);
            #1;
            waits++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; if_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1; pc = '0; inst = '0;
        repeat (2) @(negedge clk);
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", id_valid); end
        checks++; if (obs !== '0) begin failures++; $display("FAIL reset_fields: got %h want 0", obs); end
        checks++; if (if_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", if_ready); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL post_reset_valid: got %b want 0", id_valid); end
`ifdef ID_STALL_CNT_EN
        checks++; if (stall_cnt !== 32'd0) begin failures++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
`endif
    endtask

    task automatic test_addi();
        exp_t e;
        int w;
        drive(32'h100, 32'hFFC08293,
              mk(32'h100, 32'h10, 32'hFFFFFFFC, 0, 32'hFFFFFFFC, 5, 1, 0, 0, 0, 0, 5'b00000), w);
        if_valid = 1'b0;
        e = sb.pop_front();
        checks++; if (w !== 0) begin failures++; $display("FAIL addi_accept_wait: got %0d want 0", w); end
        checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL addi_valid: got %b want 1", id_valid); end
        checks++; if (id_op_b !== 32'hFFFFFFFC) begin failures++; $display("FAIL addi_op_b: got %h want fffffffc", id_op_b); end
        checks++; if (obs !== e) begin failures++; $display("FAIL addi_fields: got %h want %h", obs, e); end
        @(negedge clk);
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL addi_drain: got %b want 0", id_valid); end
    endtask

    task automatic test_load_use();
        exp_t e;
        int w;
        drive(32'h104, 32'h00012303,
              mk(32'h104, 32'h20, 0, 0, 0, 6, 1, 1, 0, 0, 0, 5'b00000), w);
        e = sb.pop_front();
        checks++; if (obs !== e || id_valid !== 1'b1) begin failures++; $display("FAIL lw_fields: got %h want %h", obs, e); end
        sb.push_back(mk(32'h108, 32'h60, 32'h30, 0, 0, 7, 1, 0, 0, 0, 0, 5'b00000));
        pc = 32'h108; inst = 32'h003303B3;
        #1;
        checks++; if (if_ready !== 1'b0) begin failures++; $display("FAIL hazard_ready: got %b want 0", if_ready); end
        @(negedge clk);
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL hazard_bubble: got %b want 0", id_valid); end
        #1;
        checks++; if (if_ready !== 1'b1) begin failures++; $display("FAIL stall_release_ready: got %b want 1", if_ready); end
        @(negedge clk);
        if_valid = 1'b0;
        e = sb.pop_front();
        checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL add_valid: got %b want 1", id_valid); end
        checks++; if (obs !== e) begin failures++; $display("FAIL add_fields: got %h want %h", obs, e); end
    endtask

    task automatic test_hold();
        exp_t e;
        int w;
        logic [31:0] cnt0;
        drive(32'h10C, 32'h403100B3,
              mk(32'h10C, 32'h20, 32'h30, 0, 0, 1, 1, 0, 0, 0, 0, 5'b01000), w);
        ex_ready = 1'b0;
        pc = 32'h110; inst = 32'hFE000CE3;
`ifdef ID_STALL_CNT_EN
        cnt0 = stall_cnt;
`else
        cnt0 = '0;
`endif
        e = sb.pop_front();
        checks++; if (obs !== e) begin failures++; $display("FAIL sub_fields: got %h want %h", obs, e); end
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (if_ready !== 1'b0) begin failures++; $display("FAIL hold_ready[%0d]: got %b want 0", i, if_ready); end
            @(negedge clk);
            checks++; if (obs !== e || id_valid !== 1'b1) begin failures++; $display("FAIL hold_fields[%0d]: got %h want %h", i, obs, e); end
        end
`ifdef ID_STALL_CNT_EN
        checks++; if (stall_cnt - cnt0 !== 32'd3) begin failures++; $display("FAIL stall_cnt_delta: got %0d want 3", stall_cnt - cnt0); end
`endif
        ex_ready = 1'b1;
        sb.push_back(mk(32'h110, 0, 0, 0, 32'hFFFFFFF8, 25, 0, 0, 0, 1, 0, 5'b10000));
        #1;
        checks++; if (if_ready !== 1'b1) begin failures++; $display("FAIL hold_release_ready: got %b want 1", if_ready); end
        @(negedge clk);
        if_valid = 1'b0;
        e = sb.pop_front();
        checks++; if (id_imm !== 32'hFFFFFFF8) begin failures++; $display("FAIL beq_imm: got %h want fffffff8", id_imm); end
        checks++; if (obs !== e || id_valid !== 1'b1) begin failures++; $display("FAIL beq_fields: got %h want %h", obs, e); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] insts [7];
        exp_t        exps [7];
        exp_t        e;
        int          w;
        insts[0] = 32'h12345437; exps[0] = mk(32'h500, 0, 32'h12345000, 0, 32'h12345000, 8, 1, 0, 0, 0, 0, 5'b00000);
        insts[1] = 32'hFFFFF497; exps[1] = mk(32'h504, 32'h504, 32'hFFFFF000, 0, 32'hFFFFF000, 9, 1, 0, 0, 0, 0, 5'b00000);
        insts[2] = 32'hFFDFF0EF; exps[2] = mk(32'h508, 32'h508, 32'hFFFFFFFC, 0, 32'hFFFFFFFC, 1, 1, 0, 0, 1, 0, 5'b00000);
        insts[3] = 32'h00828067; exps[3] = mk(32'h50C, 32'h50, 32'h8, 0, 32'h8, 0, 0, 0, 0, 1, 0, 5'b00000);
        insts[4] = 32'hFE712E23; exps[4] = mk(32'h510, 32'h20, 32'hFFFFFFFC, 32'h70, 32'hFFFFFFFC, 28, 0, 0, 1, 0, 0, 5'b00000);
        insts[5] = 32'h4035D513; exps[5] = mk(32'h514, 32'hB0, 32'h403, 0, 32'h403, 10, 1, 0, 0, 0, 0, 5'b01101);
        insts[6] = 32'hC006C613; exps[6] = mk(32'h518, 32'hD0, 32'hFFFFFC00, 0, 32'hFFFFFC00, 12, 1, 0, 0, 0, 0, 5'b00100);
        for (int i = 0; i < 7; i++) begin
            drive(exps[i].pc, insts[i], exps[i], w);
            e = sb.pop_front();
            checks++; if (w !== 0 || id_valid !== 1'b1) begin failures++; $display("FAIL b2b_issue[%0d]: got wait=%0d valid=%b want wait=0 valid=1", i, w, id_valid); end
            checks++; if (obs !== e) begin failures++; $display("FAIL b2b_fields[%0d]: got %h want %h", i, obs, e); end
        end
        if_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_flush();
        exp_t e;
        int w;
        drive(32'h200, 32'h00012303, mk(32'h200, 32'h20, 0, 0, 0, 6, 1, 1, 0, 0, 0, 5'b00000), w);
        void'(sb.pop_front());
        flush = 1'b1; pc = 32'h204; inst = 32'h003303B3;
        #1;
        checks++; if (if_ready !== 1'b0) begin failures++; $display("FAIL flush_ready: got %b want 0", if_ready); end
        @(negedge clk);
        flush = 1'b0;
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL flush_valid: got %b want 0", id_valid); end
        sb.push_back(mk(32'h204, 32'h60, 32'h30, 0, 0, 7, 1, 0, 0, 0, 0, 5'b00000));
        @(negedge clk);
        e = sb.pop_front();
        checks++; if (obs !== e || id_valid !== 1'b1) begin failures++; $display("FAIL post_flush_add: got %h want %h", obs, e); end
        drive(32'h208, 32'h00012303, mk(32'h208, 32'h20, 0, 0, 0, 6, 1, 1, 0, 0, 0, 5'b00000), w);
        void'(sb.pop_front());
        pc = 32'h20C; inst = 32'h003303B3;
        @(negedge clk);
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL stall_bubble2: got %b want 0", id_valid); end
        flush = 1'b1;
        #1;
        checks++; if (if_ready !== 1'b0) begin failures++; $display("FAIL stall_flush_ready: got %b want 0", if_ready); end
        @(negedge clk);
        flush = 1'b0;
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL stall_flush_valid: got %b want 0", id_valid); end
        #1;
        checks++; if (if_ready !== 1'b1) begin failures++; $display("FAIL stall_flush_run: got %b want 1", if_ready); end
        sb.push_back(mk(32'h20C, 32'h60, 32'h30, 0, 0, 7, 1, 0, 0, 0, 0, 5'b00000));
        @(negedge clk);
        if_valid = 1'b0;
        e = sb.pop_front();
        checks++; if (obs !== e || id_valid !== 1'b1) begin failures++; $display("FAIL stall_flush_add: got %h want %h", obs, e); end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int w;
        drive(32'h300, 32'h00012303, mk(32'h300, 32'h20, 0, 0, 0, 6, 1, 1, 0, 0, 0, 5'b00000), w);
        void'(sb.pop_front());
        pc = 32'h304; inst = 32'h003303B3;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (obs !== '0 || id_valid !== 1'b0) begin failures++; $display("FAIL async_reset: got %h valid=%b want 0", obs, id_valid); end
`ifdef ID_STALL_CNT_EN
        checks++; if (stall_cnt !== 32'd0) begin failures++; $display("FAIL async_reset_cnt: got %0d want 0", stall_cnt); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (if_ready !== 1'b1) begin failures++; $display("FAIL reset_run_ready: got %b want 1", if_ready); end
        sb.push_back(mk(32'h304, 32'h60, 32'h30, 0, 0, 7, 1, 0, 0, 0, 0, 5'b00000));
        @(negedge clk);
        if_valid = 1'b0;
        e = sb.pop_front();
        checks++; if (obs !== e || id_valid !== 1'b1) begin failures++; $display("FAIL reset_add: got %h want %h", obs, e); end
    endtask

    task automatic test_illegal();
        exp_t e;
        int w;
        drive(32'h400, 32'h0000007F, mk(32'h400, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b00000), w);
        e = sb.pop_front();
        checks++; if (id_ill !== e.ill || id_we !== e.we || id_valid !== 1'b1) begin failures++; $display("FAIL illegal_7f: got ill=%b we=%b want ill=1 we=0", id_ill, id_we); end
        drive(32'h404, 32'h00000FFF, mk(32'h404, 0, 0, 0, 0, 31, 0, 0, 0, 0, 1, 5'b00000), w);
        if_valid = 1'b0;
        e = sb.pop_front();
        checks++; if (id_ill !== e.ill || id_we !== e.we || id_waddr !== e.waddr) begin failures++; $display("FAIL illegal_rd31: got ill=%b we=%b rd=%0d want ill=1 we=0 rd=31", id_ill, id_we, id_waddr); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load_use();
        test_hold();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_illegal();
        checks++; if (sb.size() !== 0) begin failures++; $display("FAIL scoreboard_leftover: got %0d want 0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised successor to the single-cycle decode stage.
- Decodes RV32I instructions: operand select, I/S/B/U/J immediate generation, ALU control.
- Holds results in an internal ID/EX output register with valid/ready handshake.
- Adds load-use hazard stall (bubble insertion) and flush.
- Sits between the IF/ID register and EX; register-file read ports stay combinational.

Parameters:
- XLEN, 32, datapath/PC width (only 32 is legal for RV32I decode; immediates sign-extend to XLEN).
- RADDR_W, 5, register-file address width.
- ALUCTRL_W, 5, ALU control width; must be >=5.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- if_valid_i  in  1  IF/ID holds a valid instruction
- if_ready_o  out  1  decode accepts the instruction this cycle
- if_id_reg_pc_i  in  XLEN  instruction PC
- if_id_reg_inst_i  in  32  instruction word
- id_reg1_raddr_o  out  RADDR_W  rs1 address (combinational from inst)
- id_reg2_raddr_o  out  RADDR_W  rs2 address (combinational from inst)
- regs_reg1_rdata_i  in  XLEN  rs1 data
- regs_reg2_rdata_i  in  XLEN  rs2 data
- flush_i  in  1  kill the decode slot and the output register (branch redirect)
- ex_ready_i  in  1  EX accepts the output register
- id_valid_o  out  1  output register valid
- id_pc_o  out  XLEN  registered PC
- id_op_a_o  out  XLEN  ALU operand A
- id_op_b_o  out  XLEN  ALU operand B
- id_store_data_o  out  XLEN  rs2 data for stores
- id_imm_o  out  XLEN  sign-extended immediate
- id_reg_waddr_o  out  RADDR_W  rd
- id_reg_we_o  out  1  writes rd (forced 0 when rd==0)
- id_is_load_o  out  1  load
- id_is_store_o  out  1  store
- id_is_branch_o  out  1  branch / JAL / JALR
- id_illegal_o  out  1  unsupported opcode
- id_ALUctrl_o  out  ALUCTRL_W  ALU control

Behaviour:
- Clock/reset: single clock clk, rising-edge. Reset rst_n is asynchronous, active-low; every registered output resets to 0 (id_valid_o=0).
- Decode: opcodes LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011. Any other opcode sets illegal=1 and we=0.
- Immediates, sign-extended from inst[31]:
  - I = inst[31:20]
  - S = {inst[31:25], inst[11:7]}
  - B = {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - U = {inst[31:12], 12'b0}
  - J = {inst[31], inst[19:12], inst[20], inst[30:21], 0}
- op_a: PC for AUIPC/JAL; 0 for LUI; else rs1 data.
- op_b: rs2 data for OP/BRANCH; else imm.
- ALUctrl[3:0] = {alt, func3}:
  - alt = func7[5] for OP, and for OP-IMM with func3=101.
  - ADD (0000) for LOAD/STORE/LUI/AUIPC/JAL/JALR.
- ALUctrl[4] = 1 only for BRANCH (compare mode). Upper bits above 4 are 0.
- Acceptance:
  - out_free = !id_valid_o || ex_ready_i.
  - if_ready_o = out_free && !hazard && !flush_i.
  - Load on each clk edge only when if_valid_i && if_ready_o.
- Load-use hazard = id_valid_o && id_is_load_o && id_reg_waddr_o!=0 && (waddr==rs1 used || waddr==rs2 used).
  - rs1 is used by all opcodes except LUI/AUIPC/JAL; rs2 is used by OP/BRANCH/STORE.
- FSM states:
  - RUN: normal operation.
  - STALL: entered on hazard && ex_ready_i; a bubble is loaded (id_valid_o=0). Lasts exactly 1 cycle, then returns to RUN and the held instruction is accepted.
  - Hazard with !ex_ready_i: remain in RUN, holding the output register.
- If out_free && !accept, id_valid_o falls to 0 next cycle.
- Output register holds all fields stable while id_valid_o && !ex_ready_i.
- flush_i has priority over everything: next cycle id_valid_o=0, state=RUN, no instruction accepted that cycle.
- Reset mid-stall returns to RUN with id_valid_o=0.

Optional Feature:
- Macro ID_STALL_CNT_EN.
- Defined: adds output id_stall_cnt_o (32 bits), reset 0, which increments each cycle that if_valid_i && !if_ready_o. It wraps from 0xFFFFFFFF to 0 and is not cleared by flush_i.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- addi x5,x1,-4 (0xFFC08293), x1=0x10, ex_ready=1 -> next cycle valid=1, op_a=0x10, op_b=imm=0xFFFFFFFC, ALUctrl=00000, waddr=5, we=1.
- lw x6,0(x2) then add x7,x6,x3, both valid back-to-back -> if_ready_o=0 for 1 cycle, one bubble (id_valid_o=0), then add issues with ALUctrl=00000, op_b=x3 data.
- sub x1,x2,x3 (0x403100B3) with ex_ready_i=0 for 3 cycles -> outputs held constant, if_ready_o=0, ALUctrl=01000.
- beq offset −8 (0xFE000CE3) -> imm=0xFFFFFFF8, ALUctrl=10000, is_branch=1, we=0.
- flush_i asserted while id_valid_o=1 and in STALL -> next cycle id_valid_o=0, state RUN; rst_n pulsed low asynchronously mid-cycle -> all outputs 0 immediately.
- opcode 0x0000007F -> illegal=1, we=0. With ID_STALL_CNT_EN, the 3-cycle stall above -> counter reads 3.
